// File: rtl/freq_meter_pkg.sv
// Shared types and helpers for the slow-signal frequency meter.
// Pure declarations, no logic and no latency.
// Nothing here handles backpressure; it is consumed by freq_meter and friends.
package freq_meter_pkg;

  typedef enum logic {
    FM_IDLE    = 1'b0,
    FM_MEASURE = 1'b1
  } fm_state_t;

  // Number of periods averaged when averaging is built in, as a power of two.
  localparam int FM_AVG_LOG2 = 2;

  // Counter width needed to hold one period of target_hz counted at clk_hz.
  function automatic int fm_cnt_width(input int clk_hz, input int target_hz);
    return $clog2(clk_hz / target_hz + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Synchronizes a slow async input and emits one-cycle rise/fall pulses.
// Latency: async_in transition to rise_p/fall_p is SYNC_STAGES+1 cycles; level leads by one.
// No backpressure; pulses are single-cycle and must be consumed when seen.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_100mhz,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise_p,
  output logic fall_p
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  generate
    if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("sync_edge: SYNC_STAGES must be at least 2");
    end
  endgenerate

  assign level = sync_q[SYNC_STAGES-1];

  // Synchronizer chain followed by a registered edge detector.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      sync_q  <= '0;
      level_d <= 1'b0;
      rise_p  <= 1'b0;
      fall_p  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_d <= level;
      rise_p  <= level & ~level_d;
      fall_p  <= ~level & level_d;
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Measures period and high time of slow async sig_in in clk_100mhz cycles; optional FREQ_METER_AVG_EN averages 4 periods.
// Latency: period_valid one cycle after the closing rise_p (sig_in edge + SYNC_STAGES+2 cycles).
// No backpressure: results are held until the next update, period_valid is a one-cycle strobe.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = 24,
  parameter int MAX_PERIOD  = 12_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_100mhz,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             timeout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);

  generate
    if ((MAX_PERIOD < 1) || (longint'(MAX_PERIOD) >= (longint'(1) << CNT_W))) begin : g_bad_max
      $error("freq_meter: MAX_PERIOD must be in 1 .. 2**CNT_W-1");
    end
  endgenerate

  fm_state_t        state_q, state_d;
  logic             sig_level, rise_p, fall_p;
  logic             arm, close, expire;
  logic [CNT_W-1:0] cnt, hi_cnt, high_now;
  logic             low_seen;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_edge (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .async_in   (sig_in),
    .level      (sig_level),
    .rise_p     (rise_p),
    .fall_p     (fall_p)
  );

  // A period with no low level seen never fell: it was high for all of it.
  assign high_now = low_seen ? hi_cnt : cnt;

  // State register.
  always_ff @(posedge clk_100mhz) begin
    if (rst) state_q <= FM_IDLE;
    else     state_q <= state_d;
  end

  // Next state and control strobes; a rise on the limit cycle wins over the timeout.
  always_comb begin
    state_d = state_q;
    arm     = 1'b0;
    close   = 1'b0;
    expire  = 1'b0;
    busy    = (state_q == FM_MEASURE);
    case (state_q)
      FM_IDLE: begin
        if (rise_p) begin
          arm     = 1'b1;
          state_d = FM_MEASURE;
        end
      end
      FM_MEASURE: begin
        if (rise_p) begin
          close = 1'b1;
        end else if (cnt == MAX_CNT) begin
          expire  = 1'b1;
          state_d = FM_IDLE;
        end
      end
      default: state_d = FM_IDLE;
    endcase
  end

`ifdef FREQ_METER_AVG_EN
  logic [CNT_W+FM_AVG_LOG2-1:0] avg_acc, avg_sum;
  logic [FM_AVG_LOG2-1:0]       avg_idx;
  logic [CNT_W-1:0]             avg_mean;

  assign avg_sum  = avg_acc + {{FM_AVG_LOG2{1'b0}}, cnt};
  assign avg_mean = avg_sum[CNT_W+FM_AVG_LOG2-1:FM_AVG_LOG2];

  // Accumulate closed periods; restart the group after every full set or a timeout.
  always_ff @(posedge clk_100mhz) begin
    if (rst || expire) begin
      avg_acc <= '0;
      avg_idx <= '0;
    end else if (close) begin
      avg_acc <= (&avg_idx) ? '0 : avg_sum;
      avg_idx <= avg_idx + 1'b1;
    end
  end
`endif

  // Period/high counters and the held result registers.
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      cnt          <= '0;
      hi_cnt       <= '0;
      low_seen     <= 1'b0;
      period_out   <= '0;
      high_out     <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (arm || close) begin
        cnt      <= CNT_W'(1);
        hi_cnt   <= '0;
        low_seen <= 1'b0;
      end else if ((state_q == FM_MEASURE) && !expire) begin
        cnt <= cnt + 1'b1;
        if (fall_p)     hi_cnt   <= cnt;
        if (!sig_level) low_seen <= 1'b1;
      end
      if (close) begin
        timeout <= 1'b0;
`ifdef FREQ_METER_AVG_EN
        if (&avg_idx) begin
          period_out   <= avg_mean;
          high_out     <= high_now;
          period_valid <= 1'b1;
        end
`else
        period_out   <= cnt;
        high_out     <= high_now;
        period_valid <= 1'b1;
`endif
      end
      if (expire) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter with a result scoreboard.
// Drives square waves, a stall timeout, an edge on the limit cycle and a mid-period reset.
// Expected results are queued at each rising edge and checked on every period_valid.
module tb_freq_meter;

  localparam int CNT_W = 16;
  localparam int MAX_P = 1000;
  localparam int SYNC  = 2;
  // Edges from driving a lone rise until timeout is visible:
  // SYNC+1 to rise_p, one arming edge, MAX_P more to reach the limit and register it.
  localparam int TO_EDGES = SYNC + 2 + MAX_P;

  logic             clk_100mhz = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period_out;
  logic [CNT_W-1:0] high_out;
  logic             period_valid;
  logic             timeout;
  logic             busy;

  freq_meter #(
    .CNT_W       (CNT_W),
    .MAX_PERIOD  (MAX_P),
    .SYNC_STAGES (SYNC)
  ) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .sig_in       (sig_in),
    .period_out   (period_out),
    .high_out     (high_out),
    .period_valid (period_valid),
    .timeout      (timeout),
    .busy         (busy)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  typedef struct {
    int p;
    int h;
    bit gap;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_tests     = 0;
  int   n_fail      = 0;
  int   cyc         = 0;
  int   last_strobe = 0;

  // Reference model state.
  bit armed       = 1'b0;
  bit prev_pushed = 1'b0;
  int prev_hi     = 0;
  int prev_lo     = 0;
  int last_p      = 0;
  int last_h      = 0;
  int acc         = 0;
  int idx         = 0;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic push_period(input int p, input int h, input bit gap);
    exp_t e;
`ifdef FREQ_METER_AVG_EN
    acc += p;
    idx++;
    if (idx == 4) begin
      e.p = acc / 4;
      e.h = h;
      e.gap = 1'b0;
      sb.push_back(e);
      last_p = e.p;
      last_h = h;
      acc = 0;
      idx = 0;
    end
`else
    e.p = p;
    e.h = h;
    e.gap = gap;
    sb.push_back(e);
    last_p = p;
    last_h = h;
`endif
  endtask

  // Called as sig_in rises: closes the previous period if one was armed.
  task automatic model_rise(input int hi, input int lo);
    if (armed) push_period(prev_hi + prev_lo, prev_hi, prev_pushed);
    prev_pushed = armed;
    armed = 1'b1;
    prev_hi = hi;
    prev_lo = lo;
  endtask

  task automatic model_restart(input bit clear_outputs);
    armed = 1'b0;
    prev_pushed = 1'b0;
    acc = 0;
    idx = 0;
    if (clear_outputs) begin
      last_p = 0;
      last_h = 0;
    end
  endtask

  // One square-wave period: hi cycles high then lo cycles low; starts and ends #1 after an edge.
  task automatic pulse(input int hi, input int lo);
    model_rise(hi, lo);
    sig_in = 1'b1;
    repeat (hi) @(posedge clk_100mhz);
    #1 sig_in = 1'b0;
    repeat (lo) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_100mhz);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, period_out, 0);
    chk({tag, "_high"}, high_out, 0);
    chk({tag, "_valid"}, period_valid, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk_100mhz) begin
    if (period_valid === 1'b1) begin
      chk("sb_pending", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        chk("period_out", period_out, cur.p);
        chk("high_out", high_out, cur.h);
        if (cur.gap) chk("strobe_gap", cyc - last_strobe, cur.p);
      end
      last_strobe = cyc;
    end
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sig_in = 1'b0;
    tick(3);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // 100-cycle period, 40 high.
    repeat (5) pulse(40, 60);

    // Divider-style toggle every 51 cycles.
    repeat (4) pulse(51, 51);

    // Stall low after a single rise: timeout lands exactly on the limit.
    model_rise(51, 0);
    sig_in = 1'b1;
    for (int k = 1; k <= TO_EDGES; k++) begin
      @(posedge clk_100mhz);
      #1;
      if (k == 51) sig_in = 1'b0;
      if (k == TO_EDGES - 1) begin
        chk("timeout_early", timeout, 0);
        chk("busy_before_to", busy, 1);
      end
    end
    chk("timeout_set", timeout, 1);
    chk("busy_after_to", busy, 0);
    chk("to_period_held", period_out, last_p);
    chk("to_high_held", high_out, last_h);
    model_restart(1'b0);

    // Resume: first edge re-arms only, second clears timeout and reports.
    model_rise(40, 60);
    sig_in = 1'b1;
    tick(6);
    chk("timeout_hold", timeout, 1);
    chk("busy_rearm", busy, 1);
    tick(34);
    sig_in = 1'b0;
    tick(60);
    pulse(40, 60);
    chk("timeout_clr", timeout, 0);
    pulse(40, 60);

    // Period equal to the limit: the edge wins over the timeout.
    pulse(400, 600);
    pulse(400, 600);
    pulse(40, 60);
    chk("max_no_timeout", timeout, 0);
    chk("max_busy", busy, 1);

    // Reset in the middle of a period discards it.
    model_rise(40, 60);
    sig_in = 1'b1;
    tick(40);
    sig_in = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    chk_all_zero("midrst");
    rst = 1'b0;
    model_restart(1'b1);
    tick(49);
    repeat (3) pulse(40, 60);

    // Four differing periods from a clean start.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    model_restart(1'b1);
    tick(5);
    pulse(50, 50);
    pulse(51, 51);
    pulse(49, 49);
    pulse(52, 52);
    pulse(10, 20);

    tick(20);
    chk("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
